apb_master_bridge: RTL and testbench

//  APB requester that turns a single-outstanding valid/ready command into APB

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready command to APB SETUP/ACCESS requester.
// Optional ACCESS watchdog is built in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int NSLV    = 4,
    parameter int SEL_LSB = 6,
    parameter int TIMEOUT = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [63:0]     cmd_addr,
    input  logic [63:0]     cmd_wdata,
    output logic            rsp_valid,
    output logic [63:0]     rsp_rdata,
    output logic            rsp_err,
    output logic [NSLV-1:0] PSEL,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [63:0]     PADDR,
    output logic [63:0]     PWDATA,
    input  logic [63:0]     PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int HI = SEL_LSB + IW;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state;

    logic [IW-1:0]   sel_idx;
    logic            dec_err;
    logic [NSLV-1:0] sel_onehot;

    // Any address bit above the slave-index field, or an index past the last slave, is unmapped.
    always_comb begin
        sel_idx    = cmd_addr[SEL_LSB +: IW];
        dec_err    = (|(cmd_addr >> HI)) || (32'(sel_idx) >= 32'(NSLV));
        sel_onehot = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_idx == IW'(i)) sel_onehot[i] = 1'b1;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (dec_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_wdata;
                            PSEL    <= sel_onehot;
                            PENABLE <= 1'b0;
                            state   <= SETUP;
                        end
                    end else begin
                        // Also covers the response cycle: ready comes back one edge later.
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? 64'd0 : PRDATA;
                        state     <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed-vector self-checking bench for apb_master_bridge.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_apb_master_bridge;
    localparam int NSLV = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [63:0]     cmd_addr, cmd_wdata;
    logic            rsp_valid, rsp_err;
    logic [63:0]     rsp_rdata;
    logic [NSLV-1:0] PSEL;
    logic            PENABLE, PWRITE;
    logic [63:0]     PADDR, PWDATA, PRDATA;
    logic            PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_master_bridge dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Full command from IDLE: setup, `waits` wait states, response, ready recovery.
    task automatic do_xfer(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                           input int waits, input logic [63:0] rd, input logic serr,
                           input logic [NSLV-1:0] exp_psel, input logic [63:0] exp_rd,
                           input logic exp_err);
        check_val("pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check_val("setup_psel", PSEL, exp_psel);
        check_val("setup_pen", PENABLE, 0);
        check_val("setup_paddr", PADDR, addr);
        check_val("setup_pwrite", PWRITE, wr);
        check_val("setup_ready", cmd_ready, 0);
        if (wr) check_val("setup_pwdata", PWDATA, wd);
        for (int i = 0; i <= waits; i++) begin
            @(negedge PCLK);
            check_val("acc_psel", PSEL, exp_psel);
            check_val("acc_pen", PENABLE, 1);
            check_val("acc_paddr", PADDR, addr);
            check_val("acc_pwrite", PWRITE, wr);
            check_val("acc_rsp", rsp_valid, 0);
            if (i == waits) begin
                PREADY = 1'b1; PRDATA = rd; PSLVERR = serr;
            end
        end
        @(negedge PCLK);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        check_val("rsp_valid", rsp_valid, 1);
        check_val("rsp_rdata", rsp_rdata, exp_rd);
        check_val("rsp_err", rsp_err, exp_err);
        check_val("rsp_psel", PSEL, 0);
        check_val("rsp_pen", PENABLE, 0);
        check_val("rsp_ready", cmd_ready, 0);
        @(negedge PCLK);
        check_val("post_rsp", rsp_valid, 0);
        check_val("post_ready", cmd_ready, 1);
        check_val("post_rdata_hold", rsp_rdata, exp_rd);
        check_val("post_paddr_hold", PADDR, addr);
    endtask

    task automatic do_dec_err(input logic [63:0] addr, input logic [63:0] exp_paddr);
        check_val("de_pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = '0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check_val("de_rsp_valid", rsp_valid, 1);
        check_val("de_rsp_err", rsp_err, 1);
        check_val("de_rsp_rdata", rsp_rdata, 0);
        check_val("de_psel", PSEL, 0);
        check_val("de_ready", cmd_ready, 0);
        check_val("de_paddr_hold", PADDR, exp_paddr);
        @(negedge PCLK);
        check_val("de_post_rsp", rsp_valid, 0);
        check_val("de_post_psel", PSEL, 0);
        check_val("de_post_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_cycles;
        bit  got_rsp;
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        @(negedge PCLK);
        check_val("rst_ready", cmd_ready, 0);
        check_val("rst_psel", PSEL, 0);
        check_val("rst_pen", PENABLE, 0);
        check_val("rst_rsp", rsp_valid, 0);
        check_val("rst_paddr", PADDR, 0);
        PRESETn = 1'b1;
        #1 check_val("rel_ready_low", cmd_ready, 0);
        @(negedge PCLK);
        check_val("rel_ready_high", cmd_ready, 1);

        do_xfer(1'b1, 64'h45, 64'hDEAD_BEEF, 0, 64'h0, 1'b0, 4'b0010, 64'h0, 1'b0);
        do_xfer(1'b0, 64'h45, 64'h0, 3, 64'hDEAD_BEEF, 1'b0, 4'b0010, 64'hDEAD_BEEF, 1'b0);
        do_xfer(1'b0, 64'h08, 64'h0, 1, 64'h1234, 1'b1, 4'b0001, 64'h1234, 1'b1);
        do_xfer(1'b1, 64'hC0, 64'h5555_AAAA_0000_FFFF, 0, 64'h99, 1'b1, 4'b1000, 64'h0, 1'b1);

        do_dec_err(64'h100, 64'hC0);
        do_dec_err(64'h8000_0000_0000_0045, 64'hC0);

        // Slave never answers.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h80; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check_val("stuck_setup_psel", PSEL, 4'b0100);
        acc_cycles = 0;
        got_rsp    = 1'b0;
        for (int i = 0; i < 100 && !got_rsp; i++) begin
            @(negedge PCLK);
            if (rsp_valid) got_rsp = 1'b1;
            else if (PENABLE) acc_cycles++;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        check_val("tmo_rsp", got_rsp, 1);
        check_val("tmo_cycles", acc_cycles, 16);
        check_val("tmo_err", rsp_err, 1);
        check_val("tmo_rdata", rsp_rdata, 0);
        check_val("tmo_psel", PSEL, 0);
        @(negedge PCLK);
        check_val("tmo_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h80; cmd_wdata = 64'h7;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
`else
        check_val("notmo_rsp", got_rsp, 0);
        check_val("notmo_cycles", acc_cycles, 100);
`endif
        check_val("pre_rst_pen", PENABLE, 1);
        check_val("pre_rst_psel", PSEL, 4'b0100);

        #2 PRESETn = 1'b0;
        #1;
        check_val("async_psel", PSEL, 0);
        check_val("async_pen", PENABLE, 0);
        check_val("async_ready", cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check_val("rst_hold_rsp", rsp_valid, 0);
        end
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        @(negedge PCLK);
        PREADY  = 1'b0;
        check_val("rel2_ready", cmd_ready, 1);
        check_val("rel2_rsp", rsp_valid, 0);
        check_val("rel2_psel", PSEL, 0);

        do_xfer(1'b0, 64'h45, 64'h0, 0, 64'hCAFE_F00D, 1'b0, 4'b0010, 64'hCAFE_F00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
